round_robin_select: RTL

//  Round-robin arbiter that turns D request lines into one registered binary grant index.
//  It sits directly upstream of one_hot_encoder: grant_select drives the encoder's select input.

---
 rtl/round_robin_select_one_hot_encoder.sv | 16 +
 rtl/round_robin_select.sv | 104 ++++++++++
 2 files changed

// File: rtl/round_robin_select_one_hot_encoder.sv
// one_hot_encoder
//   Turns a binary index into a one-hot vector of 2**A bits.
// Ports
//   select  in   A   binary index
//   onehot  out  D   onehot[select] = 1, all other bits 0
module one_hot_encoder #(
  parameter  int A = 1,
  localparam int D = 2 ** A
) (
  input  logic [A-1:0] select,
  output logic [D-1:0] onehot
);

  assign onehot = D'(1) << select;

endmodule

// File: rtl/round_robin_select.sv
// round_robin_select
//   Round-robin arbiter: D request lines in, one registered binary grant index out,
//   paced to a downstream consumer by a valid/ready handshake.
// Ports
//   aclk          in   1  clock, rising edge
//   aresetn       in   1  asynchronous active-low reset
//   request       in   D  per-requester level request
//   grant_valid   out  1  grant_select/grant_onehot hold a valid grant
//   grant_ready   in   1  consumer accepts the grant (handshake = valid & ready)
//   grant_select  out  A  registered index of the granted requester
//   grant_onehot  out  D  one-hot of grant_select while grant_valid, else zero
//
// state | meaning
// IDLE  | no grant outstanding; a new one is loaded as soon as any request is seen
// GRANT | grant_select/grant_valid held until the consumer handshakes
module round_robin_select #(
  parameter  int A = 1,
  localparam int D = 2 ** A
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [D-1:0] request,
  output logic         grant_valid,
  input  logic         grant_ready,
  output logic [A-1:0] grant_select,
  output logic [D-1:0] grant_onehot
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state;
  logic [A-1:0] pointer;
  logic [D-1:0] select_onehot;
  logic [D-1:0] search_vec;
  logic [A-1:0] search_base;
  logic [A-1:0] winner;
  logic         found;
  logic         handshake;

  one_hot_encoder #(.A(A)) u_encoder (
    .select (grant_select),
    .onehot (select_onehot)
  );

  assign grant_onehot = select_onehot & {D{grant_valid}};
  assign handshake    = grant_valid & grant_ready;

  // In GRANT the search result is only consumed on a handshake, where the pointer is
  // about to become grant_select, so the search already starts after grant_select and
  // masks it out to keep the just-served requester from winning twice in a row.
  always_comb begin
    if (state == GRANT) begin
      search_base = grant_select;
      search_vec  = request & ~select_onehot;
    end else begin
      search_base = pointer;
      search_vec  = request;
    end
    winner = '0;
    found  = 1'b0;
    // Descending k so the smallest offset from the pointer wins.
    for (int k = D - 1; k >= 0; k--) begin
      if (search_vec[search_base + A'(k) + A'(1)]) begin
        winner = search_base + A'(k) + A'(1);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      pointer      <= '1;
      grant_select <= '0;
      grant_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_select <= winner;
            grant_valid  <= 1'b1;
            state        <= GRANT;
          end
        end
        GRANT: begin
          if (grant_ready) begin
            pointer <= grant_select;
            if (found) begin
              grant_select <= winner;
            end else begin
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
